// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 simple-interface blocks: FSM states,
// header tag and counter sizing.
package ft245_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    localparam logic [7:0] HDR_TAG = 8'h80;

    // Holds 0..max_burst so the per-grant byte counter never wraps.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/si_tx_arbiter_if.sv
// Source-side byte streams plus the FT245 tx handshake, bundled for the
// transmit arbiter (master) and whatever feeds/consumes it (slave).
interface si_tx_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_rdy;
    logic [N_SRC-1:0]   src_last;
    logic [N_SRC-1:0]   src_ack;
    logic [7:0]         tx_data_si;
    logic               tx_rdy_si;
    logic               tx_ack_si;
    logic [2:0]         grant_id;
    logic               busy;

    modport master (
        input  src_data, src_rdy, src_last, tx_ack_si,
        output src_ack, tx_data_si, tx_rdy_si, grant_id, busy
    );

    modport slave (
        output src_data, src_rdy, src_last, tx_ack_si,
        input  src_ack, tx_data_si, tx_rdy_si, grant_id, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit after 'last', wrapping around.
// Purely combinational so it can be reused on the rx command side.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    // Scan farthest-first so the nearest requester after 'last' wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IDX_W'((int'(last) + k) % N);
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/si_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the FT245 tx port among
// N_SRC byte sources, with optional source-ID header and per-grant byte cap.
//
//   state     | meaning
//   ST_IDLE   | no grant; pick next requester round-robin
//   ST_HEADER | offering 0x80|grant header byte
//   ST_DATA   | forwarding grantee's bytes until last or burst cap
module si_tx_arbiter
    import ft245_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 64,
    parameter int HEADER_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    si_tx_arbiter_if.master bus
);

    localparam int               IDX_W    = $clog2(N_SRC);
    localparam int               CNT_W    = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [CNT_W-1:0] cnt;
    logic             src_xfer;
    logic             data_done;

    rr_pick #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (bus.src_rdy),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign src_xfer = bus.tx_ack_si & bus.src_rdy[grant];

    always_comb begin
        state_nxt      = state;
        bus.tx_rdy_si  = 1'b0;
        bus.tx_data_si = '0;
        bus.src_ack    = '0;
        data_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = (HEADER_EN != 0) ? ST_HEADER : ST_DATA;
                end
            end
            ST_HEADER: begin
                // Header goes out regardless of the grantee's src_rdy.
                bus.tx_rdy_si  = 1'b1;
                bus.tx_data_si = HDR_TAG | 8'(grant);
                if (bus.tx_ack_si) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                bus.tx_rdy_si       = bus.src_rdy[grant];
                bus.tx_data_si      = bus.src_data[{grant, 3'b000} +: 8];
                bus.src_ack[grant]  = src_xfer;
                if (src_xfer && (bus.src_last[grant] || cnt == CNT_LAST)) begin
                    data_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && pick_any) begin
                grant <= pick_idx;
                cnt   <= '0;
            end
            if (state == ST_DATA && src_xfer) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (data_done) begin
                last_grant <= grant;
            end
        end
    end

    assign bus.grant_id = 3'(grant);
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_si_tx_arbiter.sv
// Bench for si_tx_arbiter: two instances (header on/off, burst cap 4) checked
// every cycle against a packet-level ownership model, plus literal wire logs.
module tb_si_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    si_tx_arbiter_if #(.N_SRC(N)) bus_a ();
    si_tx_arbiter_if #(.N_SRC(N)) bus_b ();

    si_tx_arbiter #(.N_SRC(N), .MAX_BURST(MB), .HEADER_EN(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.master));
    si_tx_arbiter #(.N_SRC(N), .MAX_BURST(MB), .HEADER_EN(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.master));

    logic [31:0] d_data [2];
    logic [3:0]  d_rdy  [2];
    logic [3:0]  d_last [2];
    logic        d_ack  [2];
    logic [7:0]  o_data [2];
    logic        o_rdy  [2];
    logic [3:0]  o_ack  [2];
    logic [2:0]  o_gid  [2];
    logic        o_busy [2];

    assign bus_a.src_data  = d_data[0];
    assign bus_a.src_rdy   = d_rdy[0];
    assign bus_a.src_last  = d_last[0];
    assign bus_a.tx_ack_si = d_ack[0];
    assign bus_b.src_data  = d_data[1];
    assign bus_b.src_rdy   = d_rdy[1];
    assign bus_b.src_last  = d_last[1];
    assign bus_b.tx_ack_si = d_ack[1];
    assign o_data[0] = bus_a.tx_data_si;
    assign o_rdy[0]  = bus_a.tx_rdy_si;
    assign o_ack[0]  = bus_a.src_ack;
    assign o_gid[0]  = bus_a.grant_id;
    assign o_busy[0] = bus_a.busy;
    assign o_data[1] = bus_b.tx_data_si;
    assign o_rdy[1]  = bus_b.tx_rdy_si;
    assign o_ack[1]  = bus_b.src_ack;
    assign o_gid[1]  = bus_b.grant_id;
    assign o_busy[1] = bus_b.busy;

    // Source byte queues and the abstract arbiter: who owns the port,
    // whether its header is still owed, and how many data bytes it has sent.
    byte unsigned qd [2][4][$];
    bit           ql [2][4][$];
    int           owner [2];
    int           last_owner [2];
    int           sent [2];
    int           gid [2];
    bit           hdr_due [2];
    bit           en [2][4];
    int           ack_mode [2];
    bit           en_rand;
    bit           rst_drv;
    bit           cmp_en;
    byte unsigned wlog [2][$];
    int           ackcnt [2][4];
    byte unsigned exp_q [$];
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        owner[d] = -1;
        last_owner[d] = N - 1;
        sent[d] = 0;
        gid[d] = 0;
        hdr_due[d] = 1'b0;
        for (int s = 0; s < N; s++) begin
            qd[d][s].delete();
            ql[d][s].delete();
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < N; s++) begin
                if (en_rand) en[d][s] = ($urandom_range(0, 3) != 0);
                d_rdy[d][s] = en[d][s] && (qd[d][s].size() > 0);
                d_data[d][8*s +: 8] = (qd[d][s].size() > 0) ? qd[d][s][0] : 8'($urandom);
                d_last[d][s] = (qd[d][s].size() > 0) ? ql[d][s][0] : 1'b0;
            end
            case (ack_mode[d])
                0:       d_ack[d] = 1'b0;
                1:       d_ack[d] = 1'b1;
                default: d_ack[d] = ($urandom_range(0, 3) != 0);
            endcase
        end
        rst = rst_drv;
    endtask

    task automatic evaluate();
        logic       exp_rdy;
        logic [7:0] exp_data;
        logic [3:0] exp_ack;
        bit         xfer;
        bit         done;
        int         s;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = 1'b0;
            exp_data = 8'h00;
            exp_ack = 4'h0;
            if (owner[d] >= 0) begin
                if (hdr_due[d]) begin
                    exp_rdy = 1'b1;
                    exp_data = 8'h80 | 8'(owner[d]);
                end else begin
                    exp_rdy = d_rdy[d][owner[d]];
                    if (exp_rdy) exp_data = qd[d][owner[d]][0];
                    exp_ack[owner[d]] = exp_rdy & d_ack[d];
                end
            end
            if (cmp_en) begin
                chk($sformatf("dut%0d tx_rdy", d), 32'(o_rdy[d]), 32'(exp_rdy));
                if (exp_rdy) chk($sformatf("dut%0d tx_data", d), 32'(o_data[d]), 32'(exp_data));
                chk($sformatf("dut%0d src_ack", d), 32'(o_ack[d]), 32'(exp_ack));
                chk($sformatf("dut%0d busy", d), 32'(o_busy[d]), 32'(owner[d] >= 0));
                chk($sformatf("dut%0d grant_id", d), 32'(o_gid[d]), 32'(gid[d]));
            end
            if (o_rdy[d] === 1'b1 && d_ack[d]) wlog[d].push_back(o_data[d]);
            for (int k = 0; k < N; k++) if (o_ack[d][k] === 1'b1) ackcnt[d][k]++;
            if (rst_drv) begin
                model_reset(d);
            end else begin
                xfer = exp_rdy & d_ack[d];
                if (owner[d] < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        s = (last_owner[d] + k) % N;
                        if (d_rdy[d][s]) begin
                            owner[d] = s;
                            gid[d] = s;
                            hdr_due[d] = (d == 0);
                            sent[d] = 0;
                            break;
                        end
                    end
                end else if (xfer) begin
                    if (hdr_due[d]) begin
                        hdr_due[d] = 1'b0;
                    end else begin
                        done = ql[d][owner[d]][0];
                        void'(qd[d][owner[d]].pop_front());
                        void'(ql[d][owner[d]].pop_front());
                        sent[d]++;
                        if (done || sent[d] == MB) begin
                            last_owner[d] = owner[d];
                            owner[d] = -1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        evaluate();
    endtask

    task automatic push_pkt(input int d, input int s, input byte unsigned b0, input int len);
        for (int i = 0; i < len; i++) begin
            qd[d][s].push_back(byte'(b0 + i));
            ql[d][s].push_back(i == len - 1);
        end
    endtask

    task automatic run_until(input int d, input int n, input int bound, input string nm);
        int c = 0;
        while (wlog[d].size() < n && c < bound) begin
            step();
            c++;
        end
        chk({nm, " byte count"}, 32'(wlog[d].size()), 32'(n));
    endtask

    task automatic chk_log(input int d, input string nm);
        chk({nm, " len"}, 32'(wlog[d].size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog[d].size(); i++)
            chk($sformatf("%s[%0d]", nm, i), 32'(wlog[d][i]), 32'(exp_q[i]));
        wlog[d].delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pending;
        int c;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            ack_mode[d] = 1;
            for (int s = 0; s < N; s++) begin
                en[d][s] = 1'b1;
                ackcnt[d][s] = 0;
            end
        end
        en_rand = 1'b0;
        cmp_en = 1'b0;
        rst_drv = 1'b1;
        repeat (3) step();
        rst_drv = 1'b0;
        cmp_en = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset dut%0d busy", d), 32'(o_busy[d]), 32'd0);
            chk($sformatf("reset dut%0d tx_rdy", d), 32'(o_rdy[d]), 32'd0);
            chk($sformatf("reset dut%0d tx_data", d), 32'(o_data[d]), 32'd0);
            chk($sformatf("reset dut%0d grant_id", d), 32'(o_gid[d]), 32'd0);
            chk($sformatf("reset dut%0d src_ack", d), 32'(o_ack[d]), 32'd0);
        end

        // Round-robin among three continuously requesting sources.
        wlog[0].delete();
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 3; s++) push_pkt(0, s, byte'(s * 16 + k), 1);
        run_until(0, 12, 60, "rr");
        exp_q = '{8'h80, 8'h00, 8'h81, 8'h10, 8'h82, 8'h20,
                  8'h80, 8'h01, 8'h81, 8'h11, 8'h82, 8'h21};
        chk_log(0, "rr");

        // Single source, three-byte packet.
        ackcnt[0][0] = 0;
        push_pkt(0, 0, 8'h11, 0);
        qd[0][0].push_back(8'h11); ql[0][0].push_back(1'b0);
        qd[0][0].push_back(8'h22); ql[0][0].push_back(1'b0);
        qd[0][0].push_back(8'h33); ql[0][0].push_back(1'b1);
        run_until(0, 4, 20, "single");
        step();
        chk("single busy after last", 32'(o_busy[0]), 32'd0);
        chk("single ack pulses", 32'(ackcnt[0][0]), 32'd3);
        exp_q = '{8'h80, 8'h11, 8'h22, 8'h33};
        chk_log(0, "single");

        // Burst cap splits src 3; src 1 slips in between the pieces.
        push_pkt(0, 3, 8'h30, 6);
        step();
        step();
        push_pkt(0, 1, 8'h10, 1);
        run_until(0, 10, 60, "burst");
        exp_q = '{8'h83, 8'h30, 8'h31, 8'h32, 8'h33, 8'h81, 8'h10, 8'h83, 8'h34, 8'h35};
        chk_log(0, "burst");

        // Backpressure then source stall mid-packet.
        ackcnt[0][2] = 0;
        push_pkt(0, 2, 8'h50, 3);
        run_until(0, 2, 20, "stall pre");
        ack_mode[0] = 0;
        repeat (5) step();
        chk("backpressure bytes", 32'(wlog[0].size()), 32'd2);
        chk("backpressure grant", 32'(o_gid[0]), 32'd2);
        ack_mode[0] = 1;
        en[0][2] = 1'b0;
        repeat (3) step();
        chk("stall bytes", 32'(wlog[0].size()), 32'd2);
        chk("stall grant", 32'(o_gid[0]), 32'd2);
        chk("stall busy", 32'(o_busy[0]), 32'd1);
        en[0][2] = 1'b1;
        run_until(0, 4, 20, "stall");
        chk("stall ack pulses", 32'(ackcnt[0][2]), 32'd3);
        exp_q = '{8'h82, 8'h50, 8'h51, 8'h52};
        chk_log(0, "stall");

        // Reset after two data bytes; src 0 wins first after reset.
        push_pkt(0, 2, 8'h60, 3);
        run_until(0, 3, 20, "rstmid pre");
        ack_mode[0] = 0;
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        ack_mode[0] = 1;
        step();
        chk("rstmid tx_rdy", 32'(o_rdy[0]), 32'd0);
        chk("rstmid busy", 32'(o_busy[0]), 32'd0);
        wlog[0].delete();
        push_pkt(0, 0, 8'h70, 1);
        push_pkt(0, 2, 8'h71, 1);
        run_until(0, 4, 20, "rstmid");
        exp_q = '{8'h80, 8'h70, 8'h82, 8'h71};
        chk_log(0, "rstmid");

        // Header-less instance.
        wlog[1].delete();
        qd[1][0].push_back(8'hAA); ql[1][0].push_back(1'b0);
        qd[1][0].push_back(8'hBB); ql[1][0].push_back(1'b1);
        qd[1][1].push_back(8'hAA); ql[1][1].push_back(1'b0);
        qd[1][1].push_back(8'hBB); ql[1][1].push_back(1'b1);
        run_until(1, 4, 20, "nohdr");
        exp_q = '{8'hAA, 8'hBB, 8'hAA, 8'hBB};
        chk_log(1, "nohdr");

        // Randomized traffic, stalls, backpressure and rare resets.
        en_rand = 1'b1;
        ack_mode[0] = 2;
        ack_mode[1] = 2;
        repeat (4000) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 11) == 0) begin
                    int s;
                    s = $urandom_range(0, N - 1);
                    if (qd[d][s].size() < 24)
                        push_pkt(d, s, byte'($urandom), $urandom_range(1, 7));
                end
            end
            rst_drv = ($urandom_range(0, 799) == 0);
            step();
        end
        rst_drv = 1'b0;

        // Drain everything still queued.
        en_rand = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ack_mode[d] = 1;
            for (int s = 0; s < N; s++) en[d][s] = 1'b1;
        end
        c = 0;
        pending = 1;
        while (pending != 0 && c < 400) begin
            step();
            c++;
            pending = 0;
            for (int d = 0; d < 2; d++) begin
                if (owner[d] >= 0) pending++;
                for (int s = 0; s < N; s++) pending += qd[d][s].size();
            end
        end
        chk("drain pending", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/si_tx_arbiter.md
# si_tx_arbiter

Shares the single FT245 simple-interface transmit port among N_SRC byte-stream sources (acquisition channels, register readback, status). Grants the port round-robin at packet granularity, prefixes each packet with a one-byte source-ID header, and caps the bytes per grant so no source can starve the others. It sits between the data producers and the tx side of the FT245 interface, which drives tx_ack_si.

## Interface
- N_SRC, 4: number of sources, 2..8.
- MAX_BURST, 64: maximum data bytes per grant, 1..256.
- HEADER_EN, 1: 1 inserts a header byte before each packet; 0 sends raw data.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_data  in  8*N_SRC  byte from source i at [8i+7:8i]
- src_rdy  in  N_SRC  source i has a byte valid
- src_last  in  N_SRC  byte on src_data[i] is the packet's last byte
- src_ack  out  N_SRC  byte from source i consumed this cycle
- tx_data_si  out  8  byte to the FT245 interface
- tx_rdy_si  out  1  tx_data_si valid
- tx_ack_si  in  1  FT245 interface accepted tx_data_si
- grant_id  out  3  index of the current or most recent grantee
- busy  out  1  state != IDLE

## Operation
- Transfer rule: a byte moves on any cycle where tx_rdy_si & tx_ack_si. tx_ack_si is ignored while tx_rdy_si=0.
- States: IDLE, HEADER, DATA. Encoding is 2 bits.
- IDLE: tx_rdy_si=0. If any src_rdy bit is set, the round-robin picker selects the first set bit, searching from last_grant+1 upward with wrap-around. The selected index is registered into grant. Next state is HEADER when HEADER_EN=1, otherwise DATA. cnt is set to 0.
- HEADER: tx_data_si = 8'h80 | grant. tx_rdy_si=1. On transfer, go to DATA. The header is offered even if the source's src_rdy drops.
- DATA: tx_data_si = src_data[grant], tx_rdy_si = src_rdy[grant], src_ack[grant] = tx_ack_si & src_rdy[grant]. All other src_ack bits are 0. On each transfer, cnt increments.
- DATA exit: on a transfer where src_last[grant]=1 or cnt==MAX_BURST-1, go to IDLE and set last_grant <= grant.
- Burst cap: if the cap ends a packet early, the remainder is sent under a later grant with a fresh header. Sources must tolerate this split.
- Source stall: if src_rdy[grant] drops mid-packet, the grant is held. There is no timeout.
- Request changes: a src_rdy bit that rises while the arbiter is busy is not considered until the next IDLE cycle.
- Width: cnt is $clog2(MAX_BURST)+1 bits and never wraps.

## Timing
- Reset values: state=IDLE, last_grant=N_SRC-1 (so source 0 wins the first arbitration), grant=0, cnt=0, grant_id=0, busy=0, tx_rdy_si=0, tx_data_si=0, src_ack=0.
- Reset mid-packet: the arbiter returns to IDLE next cycle with no further ack. The partial packet is lost, and the sources are reset with it.
- tx_rdy_si, tx_data_si and src_ack are combinational from the registered state/grant and the source inputs. They add no latency beyond the FT245 interface's combinational ack.
- Arbitration latency: a request seen in IDLE at cycle n makes the header available at n+1.
- Per-packet overhead: 1 IDLE cycle + 1 header byte.
- Back-to-back packets always pass through IDLE, so a different requester gets the next grant whenever one is waiting.
- A single-byte packet with HEADER_EN=0 occupies IDLE + 1 DATA cycle (minimum) per byte.

## Structure
- ft245_pkg holds: state localparams (ST_IDLE, ST_HEADER, ST_DATA), HDR_TAG=8'h80, and the width function for cnt. The FT245 interface block shares the same package.
- One combinational sub-module, rr_pick: inputs req[N_SRC] and last[idx]; outputs idx and any. rr_pick is reusable for a future rx command router.
- Top level: the state register, cnt, grant/last_grant, and the output muxes.

## Test plan
- Single source: src 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) with tx_ack_si tied to tx_rdy_si -> wire shows 0x80,0x11,0x22,0x33; src_ack[0] pulses 3 times; busy falls after 0x33.
- Round-robin: srcs 0,1,2 all requesting 1-byte packets continuously -> headers in the order 0x80,0x81,0x82,0x80,…; no source is granted twice in a row while others wait.
- Burst cap: MAX_BURST=4, src 3 sends a 6-byte packet -> 0x83 + 4 bytes, IDLE, 0x83 + 2 bytes. With src 1 also requesting, src 1's packet is inserted between the two pieces.
- Backpressure and stall: tx_ack_si held 0 for 5 cycles mid-packet, then src_rdy[grant] dropped for 3 cycles -> no byte is duplicated or lost, src_ack only on transfer cycles, and the grant is unchanged.
- Reset mid-packet: rst asserted during DATA after 2 bytes -> next cycle tx_rdy_si=0 and busy=0; the first grant after reset goes to src 0 even if src 2 also requests.
- HEADER_EN=0: two sources each send 0xAA then 0xBB (last) -> wire shows 0xAA,0xBB,0xAA,0xBB with no header bytes.
